// File: rtl/fir_output_requant_pkg.sv
// Shared FIR package: default sample widths and the handshake transfer definition.
// Latency: n/a (declarations only).
// Backpressure: a transfer happens when valid is high and busy is low in the same cycle.
package fir_output_requant_pkg;

  // FIR output width and the requantised sample width used along the output path.
  localparam int FIR_IWIDTH = 22;
  localparam int FIR_QWIDTH = 8;

  // A port pair moves one item whenever valid is high and busy is low.
  function automatic logic xfer(input logic valid, input logic busy);
    return valid & ~busy;
  endfunction

endpackage

// File: rtl/fir_sat_trunc.sv
// Saturating truncation of a signed word to QWIDTH bits, with a clip flag.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
//
// Ports:
//   din  - signed IWIDTH-bit input (IWIDTH must exceed QWIDTH)
//   dout - signed QWIDTH-bit result, clipped to [-2^(QWIDTH-1), 2^(QWIDTH-1)-1]
//   clip - high when din did not fit and dout was clipped
module fir_sat_trunc
  import fir_output_requant_pkg::*;
#(
  parameter int IWIDTH = FIR_IWIDTH + 1,
  parameter int QWIDTH = FIR_QWIDTH
) (
  input  logic [IWIDTH-1:0] din,
  output logic [QWIDTH-1:0] dout,
  output logic              clip
);

  logic                   sign;
  logic [IWIDTH-QWIDTH:0] upper;

  // The value fits when every bit from the output MSB upward equals the sign.
  assign sign  = din[IWIDTH-1];
  assign upper = din[IWIDTH-1:QWIDTH-1];
  assign clip  = (upper != {(IWIDTH-QWIDTH+1){sign}});

  always_comb begin
    dout = din[QWIDTH-1:0];
    if (clip) begin
      dout = sign ? {1'b1, {(QWIDTH-1){1'b0}}} : {1'b0, {(QWIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fir_output_requant.sv
// FIR output requantiser: decimate, round-shift, saturate to QWIDTH with clip count.
// Latency: 2 cycles from kept-sample accept to dout_valid; 1 sample/cycle sustained.
// Backpressure: dout_busy holds stage 2; din_busy rises when both stages are full and
//   stalled, or for the one cycle a configuration write is accepted.
//
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   cfg_valid/cfg_busy          - config write handshake; refused while samples are in flight
//   cfg_shift, cfg_decim        - right-shift amount, keep 1 of every cfg_decim+1 samples
//   din_valid/din_busy/din_data - signed FIR result input
//   dout_valid/dout_busy        - requantised sample output handshake
//   dout_data, dout_sat         - signed output sample and its clip flag
//   sat_cnt                     - saturating count of clipped samples transferred out
module fir_output_requant
  import fir_output_requant_pkg::*;
#(
  parameter int IWIDTH = FIR_IWIDTH,
  parameter int QWIDTH = FIR_QWIDTH,
  parameter int SWIDTH = 5,
  parameter int MWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_busy,
  input  logic [SWIDTH-1:0] cfg_shift,
  input  logic [MWIDTH-1:0] cfg_decim,
  input  logic              din_valid,
  output logic              din_busy,
  input  logic [IWIDTH-1:0] din_data,
  output logic              dout_valid,
  input  logic              dout_busy,
  output logic [QWIDTH-1:0] dout_data,
  output logic              dout_sat,
  output logic [15:0]       sat_cnt
);

  logic [SWIDTH-1:0]        shift;
  logic [MWIDTH-1:0]        decim;
  logic [MWIDTH-1:0]        phase;
  logic                     s1_valid;
  logic signed [IWIDTH:0]   s1_data;
  logic signed [IWIDTH:0]   rnd;
  logic signed [IWIDTH:0]   s1_next;
  logic [QWIDTH-1:0]        s2_data;
  logic                     s2_clip;
  logic                     cfg_acc;
  logic                     din_acc;
  logic                     keep;
  logic                     adv;
  logic                     dout_xfer;

  assign cfg_busy  = s1_valid | dout_valid;
  assign cfg_acc   = xfer(cfg_valid, cfg_busy);
  // A config write takes the cycle, so data waits even if the stages are empty.
  assign din_busy  = cfg_acc | (s1_valid & dout_valid & dout_busy);
  assign din_acc   = xfer(din_valid, din_busy);
  assign keep      = din_acc & (phase == '0);
  assign dout_xfer = xfer(dout_valid, dout_busy);
  assign adv       = ~dout_valid | ~dout_busy;

  // One extra bit of headroom so adding the rounding constant never overflows.
  always_comb begin
    rnd = '0;
    if (shift != '0) begin
      rnd = {{IWIDTH{1'b0}}, 1'b1} << (shift - 1'b1);
    end
    s1_next = ($signed({din_data[IWIDTH-1], din_data}) + rnd) >>> shift;
  end

  fir_sat_trunc #(
    .IWIDTH(IWIDTH + 1),
    .QWIDTH(QWIDTH)
  ) u_sat (
    .din  (s1_data),
    .dout (s2_data),
    .clip (s2_clip)
  );

  // Configuration and decimation phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      decim <= '0;
      phase <= '0;
    end else if (cfg_acc) begin
      if (32'(cfg_shift) > 32'(IWIDTH - 1)) begin
        shift <= SWIDTH'(IWIDTH - 1);
      end else begin
        shift <= cfg_shift;
      end
      decim <= cfg_decim;
      phase <= '0;
    end else if (din_acc) begin
      phase <= (phase == decim) ? '0 : phase + 1'b1;
    end
  end

  // Stage 1: rounded shift. A new sample is only accepted when this stage
  // will be free at the edge, so loading has priority over draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (keep) begin
      s1_valid <= 1'b1;
      s1_data  <= s1_next;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: saturated output register, held while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_sat   <= 1'b0;
    end else if (adv) begin
      dout_valid <= s1_valid;
      if (s1_valid) begin
        dout_data <= s2_data;
        dout_sat  <= s2_clip;
      end
    end
  end

  // Clip counter. A config write can only land while the output is empty,
  // so clearing and counting never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cfg_acc) begin
      sat_cnt <= '0;
    end else if (dout_xfer && dout_sat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fir_output_requant.sv
module tb_fir_output_requant;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_busy;
  logic [4:0]  cfg_shift;
  logic [3:0]  cfg_decim;
  logic        din_valid;
  logic        din_busy;
  logic [21:0] din_data;
  logic        dout_valid;
  logic        dout_busy;
  logic [7:0]  dout_data;
  logic        dout_sat;
  logic [15:0] sat_cnt;

  int total = 0;
  int bad   = 0;
  int outq[$];
  logic held = 1'b0;
  int   held_dat = 0;
  logic saw_din_busy = 1'b0;

  fir_output_requant #(
    .IWIDTH(22), .QWIDTH(8), .SWIDTH(5), .MWIDTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_busy   (cfg_busy),
    .cfg_shift  (cfg_shift),
    .cfg_decim  (cfg_decim),
    .din_valid  (din_valid),
    .din_busy   (din_busy),
    .din_data   (din_data),
    .dout_valid (dout_valid),
    .dout_busy  (dout_busy),
    .dout_data  (dout_data),
    .dout_sat   (dout_sat),
    .sat_cnt    (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Output monitor: collect every transfer, and check that a stalled output holds.
  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (held) chk("hold_dat", int'($signed(dout_data)), held_dat);
      if (!dout_busy) outq.push_back(int'($signed(dout_data)));
    end
    if (rst_n && din_valid && din_busy && dout_busy) saw_din_busy = 1'b1;
    held     = rst_n && dout_valid && dout_busy;
    held_dat = int'($signed(dout_data));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_cfg(input int sh, input int dc);
    int   n = 0;
    logic ok;
    cfg_valid = 1'b1;
    cfg_shift = 5'(sh);
    cfg_decim = 4'(dc);
    do begin
      @(negedge clk);
      ok = !cfg_busy;
      tick();
      n++;
    end while (!ok && n < 50);
    cfg_valid = 1'b0;
    chk("cfg_accept", int'(ok), 1);
  endtask

  // Present one sample and hold it until accepted; returns just after the accepting edge.
  task automatic push(input int v);
    int   n = 0;
    logic ok;
    din_valid = 1'b1;
    din_data  = 22'(v);
    do begin
      @(negedge clk);
      ok = !din_busy;
      tick();
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  // Single sample with latency check: invisible one cycle after accept, valid the next.
  task automatic send_one(input string tag, input int v, input int exp_d, input int exp_s);
    din_valid = 1'b1;
    din_data  = 22'(v);
    @(negedge clk);
    chk({tag, "_acc"}, int'(din_busy), 0);
    tick();
    din_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, int'(dout_valid), 0);
    @(negedge clk);
    chk({tag, "_vld"}, int'(dout_valid), 1);
    chk({tag, "_dat"}, int'($signed(dout_data)), exp_d);
    chk({tag, "_sat"}, int'(dout_sat), exp_s);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_shift = '0; cfg_decim = '0;
    din_valid = 1'b0; din_data = '0; dout_busy = 1'b0;
    #3;
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_dout_data", int'(dout_data), 0);
    chk("rst_sat_cnt", int'(sat_cnt), 0);
    chk("rst_cfg_busy", int'(cfg_busy), 0);
    chk("rst_din_busy", int'(din_busy), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Rounded shift by 4.
    do_cfg(4, 0);
    send_one("sh4_pos", 263, 16, 0);
    send_one("sh4_neg", -263, -16, 0);

    // Saturation and clip counting.
    do_cfg(0, 0);
    send_one("sat_pos", 300, 127, 1);
    send_one("sat_neg", -300, -128, 1);
    idle(2);
    @(negedge clk);
    chk("sat_cnt2", int'(sat_cnt), 2);

    // Decimation by 3; config also clears the clip count.
    do_cfg(0, 2);
    @(negedge clk);
    chk("sat_cnt_clr", int'(sat_cnt), 0);
    tick();
    outq.delete();
    for (int v = 1; v <= 7; v++) push(v);
    din_valid = 1'b0;
    idle(5);
    chk("dec_n", outq.size(), 3);
    if (outq.size() == 3) begin
      chk("dec_0", outq[0], 1);
      chk("dec_1", outq[1], 4);
      chk("dec_2", outq[2], 7);
    end

    // Continuous stream with a 3-cycle downstream stall.
    do_cfg(0, 0);
    outq.delete();
    saw_din_busy = 1'b0;
    fork
      begin
        for (int v = 10; v <= 19; v++) push(v);
        din_valid = 1'b0;
      end
      begin
        idle(4);
        dout_busy = 1'b1;
        idle(3);
        dout_busy = 1'b0;
      end
    join
    idle(6);
    chk("stall_n", outq.size(), 10);
    chk("stall_din_busy", int'(saw_din_busy), 1);
    for (int i = 0; i < outq.size() && i < 10; i++) chk("stall_val", outq[i], 10 + i);

    // Config refused while an output is pending.
    outq.delete();
    dout_busy = 1'b1;
    push(5);
    din_valid = 1'b0;
    idle(3);
    cfg_valid = 1'b1; cfg_shift = 5'd7; cfg_decim = 4'd3;
    @(negedge clk);
    chk("cfg_refused", int'(cfg_busy), 1);
    tick();
    cfg_valid = 1'b0;
    dout_busy = 1'b0;
    idle(3);
    push(100);
    push(101);
    din_valid = 1'b0;
    idle(5);
    chk("keep_n", outq.size(), 3);
    if (outq.size() == 3) begin
      chk("keep_0", outq[0], 5);
      chk("keep_1", outq[1], 100);
      chk("keep_2", outq[2], 101);
    end

    // Config and data together when idle: config wins, data waits a cycle.
    outq.delete();
    cfg_valid = 1'b1; cfg_shift = 5'd1; cfg_decim = 4'd0;
    din_valid = 1'b1; din_data = 22'd50;
    @(negedge clk);
    chk("both_cfg_busy", int'(cfg_busy), 0);
    chk("both_din_busy", int'(din_busy), 1);
    tick();
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("both_din_next", int'(din_busy), 0);
    tick();
    din_valid = 1'b0;
    idle(4);
    chk("both_n", outq.size(), 1);
    if (outq.size() == 1) chk("both_val", outq[0], 25);

    // Reset with two samples in flight.
    outq.delete();
    push(60);
    push(61);
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", int'(dout_valid), 0);
    chk("mid_rst_sat_cnt", int'(sat_cnt), 0);
    chk("mid_rst_cfg_busy", int'(cfg_busy), 0);
    idle(2);
    rst_n = 1'b1;
    idle(6);
    chk("no_stale_n", outq.size(), 0);
    @(negedge clk);
    chk("no_stale_vld", int'(dout_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/fir_output_requant.md
FIR_OUTPUT_REQUANT -- requirements
Module: fir_output_requant

Interface
REQ-001 SHALL have parameter IWIDTH, default 22, input sample width; matches FIR OWIDTH.
REQ-002 SHALL have parameter QWIDTH, default 8, output sample width.
REQ-003 SHALL have parameter SWIDTH, default 5, shift-config width.
REQ-004 SHALL have parameter MWIDTH, default 4, decimation-config width.
REQ-005 SHALL have port clk, input, 1 bit; single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-007 SHALL have port cfg_valid, input, 1 bit; configuration write request.
REQ-008 SHALL have port cfg_busy, output, 1 bit; configuration write refused.
REQ-009 SHALL have port cfg_shift, input, SWIDTH bits; right-shift amount.
REQ-010 SHALL have port cfg_decim, input, MWIDTH bits; keep 1 of every cfg_decim+1 samples.
REQ-011 SHALL have port din_valid, input, 1 bit; upstream sample valid.
REQ-012 SHALL have port din_busy, output, 1 bit; upstream stall.
REQ-013 SHALL have port din_data, input, IWIDTH bits; signed two's-complement FIR result.
REQ-014 SHALL have port dout_valid, output, 1 bit; output sample valid.
REQ-015 SHALL have port dout_busy, input, 1 bit; downstream stall.
REQ-016 SHALL have port dout_data, output, QWIDTH bits; signed requantised sample.
REQ-017 SHALL have port dout_sat, output, 1 bit; the current dout_data was clipped.
REQ-018 SHALL have port sat_cnt, output, 16 bits; count of clipped output samples.

Function
REQ-019 SHALL define a transfer on any port pair as valid high and busy low in the same cycle.
REQ-020 SHALL accept configuration only when cfg_busy is low; cfg_busy = s1_valid OR dout_valid (combinational).
REQ-021 SHALL, on cfg accept, latch shift (clamped to IWIDTH-1) and decim, reset phase counter to 0, and clear sat_cnt.
REQ-022 SHALL drive din_busy = (cfg_valid AND NOT cfg_busy) OR (s1_valid AND dout_valid AND dout_busy); config has priority over data.
REQ-023 SHALL increment the phase counter on every accepted input sample, wrapping from decim to 0; a sample SHALL enter stage 1 only when phase = 0, otherwise it is discarded.
REQ-024 SHALL, in stage 1, register (din_data + round) >>> shift, with round = 2^(shift-1) for shift > 0 and 0 for shift = 0, using an arithmetic shift and IWIDTH+1-bit arithmetic (no overflow).
REQ-025 SHALL, in stage 2, saturate to [-2^(QWIDTH-1), 2^(QWIDTH-1)-1], register the result to dout_data, and set dout_sat when clipping occurred.
REQ-026 SHALL have a latency of 2 cycles from kept-sample accept to dout_valid when unstalled, and sustain 1 sample per cycle.
REQ-027 SHALL advance stage 1 into stage 2 when dout_valid is low or an output transfer occurs; while dout_valid and dout_busy are high, dout_data/dout_sat SHALL hold stable and no sample SHALL be lost or duplicated.
REQ-028 SHALL increment sat_cnt on each output transfer with dout_sat high, saturating at 0xFFFF.
REQ-029 SHALL, for decim = 0, pass every sample.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear: dout_valid, s1_valid, dout_data, dout_sat, sat_cnt, phase, shift, decim -> 0; din_busy/cfg_busy then evaluate low.
REQ-031 SHALL discard in-flight samples on reset mid-stream and produce no output until new input.

Structure
REQ-032 SHALL place the handshake transfer definition and the default widths (IWIDTH, QWIDTH) in the shared FIR package.
REQ-033 SHALL implement stage 2 as one sub-module, fir_sat_trunc (combinational saturate plus clip flag), reused by other FIR output paths.

Verification (QWIDTH=8, IWIDTH=22)
REQ-034 SHALL verify: shift=4, decim=0; din 263 -> dout 16, sat 0; din -263 -> dout -16; each 2 cycles after accept.
REQ-035 SHALL verify: shift=0; din 300 -> 127 with sat 1; din -300 -> -128 with sat 1; sat_cnt = 2.
REQ-036 SHALL verify: decim=2; stream 1..7 at shift 0 -> outputs 1, 4, 7 only.
REQ-037 SHALL verify: continuous stream 10..19 with dout_busy high 3 cycles mid-stream -> all 10 values out in order, din_busy asserted during the stall, no duplicates.
REQ-038 SHALL verify: cfg_valid while dout_valid high -> cfg_busy high, config unchanged; cfg and din_valid together when idle -> cfg accepted, din stalled 1 cycle.
REQ-039 SHALL verify: rst_n pulsed low with 2 samples in flight -> dout_valid 0 immediately, sat_cnt 0, no stale output after release.
